// File: rtl/axi_burst_write_master_if.sv
// AXI4 write-channel bundle (AW/W/B) for the burst write master.
// Master drives addresses, data and BREADY; slave drives the ready/response side.
interface axi_burst_write_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 512
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
    output M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
    output M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
    input  M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
    input  M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/axi_burst_write_master.sv
// Streams input words through a staging FIFO into AXI4 INCR write bursts,
// one burst in flight, with flush for partial bursts and sticky error flag.
module axi_burst_write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 10,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH         = 16,
  parameter int BURST_LEN          = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_base_addr,
  input  logic                          i_flush,
  input  logic                          s_valid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_data,
  output logic                          s_ready,
  output logic                          o_busy,
  output logic                          o_err,
  axi_burst_write_master_if.master      m_axi
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int LW    = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE, AWS, WS, BS
  } state_t;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] beats;
  logic [LW-1:0] beat_cnt;
  logic          flush_pending;
  logic          awvalid;
  logic          wvalid;
  logic          wlast;
  logic          bready;
  logic          err;
  logic          launch;

  assign s_ready = !M_AXI_ARESET
                && (count < CW'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = wvalid && m_axi.M_AXI_WREADY;
  assign launch  = (count >= CW'(BURST_LEN))
                || (flush_pending && count != '0);

  assign o_busy = (state != IDLE);
  assign o_err  = err;

  assign m_axi.M_AXI_AWADDR  = cur_addr;
  assign m_axi.M_AXI_AWLEN   = 8'(beats) - 8'd1;
  assign m_axi.M_AXI_AWSIZE  = 3'($clog2(BYTES));
  assign m_axi.M_AXI_AWBURST = 2'b01;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = mem[rd_ptr];
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WLAST   = wlast;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;

  always_ff @(posedge M_AXI_ACLK) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      cur_addr      <= '0;
      beats         <= '0;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
      awvalid       <= 1'b0;
      wvalid        <= 1'b0;
      wlast         <= 1'b0;
      bready        <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (i_flush) flush_pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            cur_addr <= i_base_addr;
            err      <= 1'b0;
          end
          if (launch) begin
            beats    <= (count >= CW'(BURST_LEN))
                      ? LW'(BURST_LEN) : LW'(count);
            beat_cnt <= '0;
            awvalid  <= 1'b1;
            state    <= AWS;
          end else if (count == '0 && !i_flush) begin
            flush_pending <= 1'b0;
          end
        end
        AWS: begin
          if (m_axi.M_AXI_AWREADY) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wlast   <= (beats == LW'(1));
            state   <= WS;
          end
        end
        WS: begin
          if (m_axi.M_AXI_WREADY) begin
            beat_cnt <= beat_cnt + LW'(1);
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= BS;
            end else begin
              wlast <= (beat_cnt + LW'(2) == beats);
            end
          end
        end
        BS: begin
          if (m_axi.M_AXI_BVALID) begin
            bready <= 1'b0;
            if (m_axi.M_AXI_BRESP != 2'b00) err <= 1'b1;
            // address space wraps modulo 2^AW
            cur_addr <= cur_addr
                      + AW'(int'(beats) * BYTES);
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: full, flush, backpressure,
// error/wrap, FIFO-full and mid-burst reset scenarios.
module tb_axi_burst_write_master;

  localparam int AW = 10;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic          i_flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          o_busy;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  axi_burst_write_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_burst_write_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .FIFO_DEPTH(16),
    .BURST_LEN(16)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .i_start(i_start),
    .i_base_addr(i_base_addr),
    .i_flush(i_flush),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .o_busy(o_busy),
    .o_err(o_err),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_n(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(first + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] base);
    i_base_addr = base;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic flush();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  task automatic run_burst(input logic [AW-1:0] addr,
                           input int nb,
                           input int first,
                           input bit tog);
    int   cyc;
    int   n;
    bit   stalled;
    logic pv;
    logic pl;
    logic [DW-1:0] pd;
    cyc = 0;
    n = 0;
    stalled = 1'b0;
    while (!bus.M_AXI_AWVALID && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("awvalid", 512'(bus.M_AXI_AWVALID), 512'(1));
    chk("w_before_aw", 512'(bus.M_AXI_WVALID), 512'(0));
    chk("awaddr", 512'(bus.M_AXI_AWADDR), 512'(addr));
    chk("awlen", 512'(bus.M_AXI_AWLEN), 512'(nb - 1));
    chk("awsize", 512'(bus.M_AXI_AWSIZE), 512'(6));
    chk("awburst", 512'(bus.M_AXI_AWBURST), 512'(1));
    while (n < nb && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.M_AXI_WREADY = tog ? ~bus.M_AXI_WREADY : 1'b1;
      if (stalled) begin
        chk("stall_wvalid", 512'(bus.M_AXI_WVALID), 512'(pv));
        chk("stall_wdata", 512'(bus.M_AXI_WDATA), 512'(pd));
        chk("stall_wlast", 512'(bus.M_AXI_WLAST), 512'(pl));
      end
      stalled = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      pv = bus.M_AXI_WVALID;
      pd = bus.M_AXI_WDATA;
      pl = bus.M_AXI_WLAST;
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        chk("wdata", 512'(bus.M_AXI_WDATA), 512'(first + n));
        chk("wlast", 512'(bus.M_AXI_WLAST), 512'(n == nb - 1));
        n++;
      end
    end
    bus.M_AXI_WREADY = 1'b1;
    while (o_busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("beats", 512'(n), 512'(nb));
    chk("idle_after", 512'(o_busy), 512'(0));
  endtask

  initial begin
    int c;
    int n;
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    bus.M_AXI_BVALID  = 1'b1;
    bus.M_AXI_BRESP   = 2'b00;

    repeat (2) @(negedge clk);
    chk("rst_sready", 512'(s_ready), 512'(0));
    chk("rst_busy", 512'(o_busy), 512'(0));
    chk("rst_awvalid", 512'(bus.M_AXI_AWVALID), 512'(0));
    chk("rst_wvalid", 512'(bus.M_AXI_WVALID), 512'(0));
    chk("rst_wlast", 512'(bus.M_AXI_WLAST), 512'(0));
    chk("rst_bready", 512'(bus.M_AXI_BREADY), 512'(0));
    chk("rst_err", 512'(o_err), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("sready_rel", 512'(s_ready), 512'(1));

    // full burst
    start(10'h000);
    push_n(0, 16);
    run_burst(10'h000, 16, 0, 1'b0);

    // partial flush
    start(10'h100);
    push_n(100, 5);
    flush();
    run_burst(10'h100, 5, 100, 1'b0);
    chk("flush_count", 512'(dut.count), 512'(0));

    // W backpressure, address continues at 0x100 + 5*64
    push_n(200, 16);
    run_burst(10'h240, 16, 200, 1'b1);

    // error response then wrap past the top of the address space
    start(10'h3C0);
    bus.M_AXI_BRESP = 2'b10;
    push_n(300, 1);
    flush();
    run_burst(10'h3C0, 1, 300, 1'b0);
    chk("err_set", 512'(o_err), 512'(1));
    bus.M_AXI_BRESP = 2'b00;
    push_n(400, 16);
    run_burst(10'h000, 16, 400, 1'b0);
    chk("err_sticky", 512'(o_err), 512'(1));
    start(10'h000);
    chk("err_clear", 512'(o_err), 512'(0));

    // FIFO full with AW stalled
    start(10'h080);
    bus.M_AXI_AWREADY = 1'b0;
    push_n(500, 16);
    chk("full_sready", 512'(s_ready), 512'(0));
    repeat (3) @(negedge clk);
    chk("aw_hold_valid", 512'(bus.M_AXI_AWVALID), 512'(1));
    chk("aw_hold_addr", 512'(bus.M_AXI_AWADDR), 512'(10'h080));
    s_valid = 1'b1;
    s_data  = DW'(516);
    @(negedge clk);
    chk("w17_blocked", 512'(s_ready), 512'(0));
    chk("full_count", 512'(dut.count), 512'(16));
    bus.M_AXI_AWREADY = 1'b1;
    fork
      run_burst(10'h080, 16, 500, 1'b0);
      begin
        c = 0;
        while (!s_ready && c < 100) begin
          @(negedge clk);
          c++;
        end
        chk("w17_accept", 512'(s_ready), 512'(1));
        @(negedge clk);
        s_valid = 1'b0;
      end
    join
    chk("w17_count", 512'(dut.count), 512'(1));
    flush();
    run_burst(10'h080, 1, 516, 1'b0);

    // reset in the middle of a burst
    push_n(600, 16);
    c = 0;
    n = 0;
    while (n < 7 && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) n++;
    end
    chk("mid_beats", 512'(n), 512'(7));
    rst = 1'b1;
    @(negedge clk);
    chk("mr_awvalid", 512'(bus.M_AXI_AWVALID), 512'(0));
    chk("mr_wvalid", 512'(bus.M_AXI_WVALID), 512'(0));
    chk("mr_bready", 512'(bus.M_AXI_BREADY), 512'(0));
    chk("mr_busy", 512'(o_busy), 512'(0));
    chk("mr_count", 512'(dut.count), 512'(0));
    chk("mr_sready", 512'(s_ready), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mr_sready_rel", 512'(s_ready), 512'(1));

    // recovery after reset: address restarts at 0
    push_n(700, 2);
    flush();
    run_burst(10'h000, 2, 700, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
